// File: rtl/serial_to_parallel_rx_pkg.sv
// Shared constants, FSM state type and parity helper for the serial link (rx and tx sides).
// Optional feature macro: PARITY_EN (adds one trailing even-parity bit per frame).
package serial_link_pkg;

    localparam int FRAME_BITS = 8;

`ifdef PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam int FRAME_LEN = FRAME_BITS + PARITY_BITS;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

`ifdef PARITY_EN
    function automatic logic even_parity(input logic [FRAME_BITS-1:0] data);
        return ^data;
    endfunction
`endif

endpackage

// File: rtl/serial_to_parallel_rx_if.sv
// Link-side and consumer-side signals of the serial receiver bundled as one interface.
interface serial_to_parallel_rx_if;
    import serial_link_pkg::*;

    logic                  vi;
    logic                  sin;
    logic                  ack;
    logic [FRAME_BITS-1:0] dout;
    logic                  rdy;
    logic                  ovf;
    logic                  err;

    modport master (output vi, sin, ack, input dout, rdy, ovf, err);
    modport slave  (input vi, sin, ack, output dout, rdy, ovf, err);

endinterface

// File: rtl/serial_to_parallel_rx_bit_counter.sv
// Clear/enable bit counter with terminal-count flag; shared by the rx and tx controllers.
module rx_bit_counter #(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] LAST  = '1
) (
    input  logic             ck,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_r;

    // count register: clear has priority over enable
    always_ff @(posedge ck) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + WIDTH'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == LAST);

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: LSB-first frame assembly, ready/ack hold, sticky overrun, error pulse.
// Optional feature macro: PARITY_EN (trailing even-parity bit checked, bad words dropped).
module serial_to_parallel_rx
    import serial_link_pkg::*;
(
    input  logic                    ck,
    input  logic                    reset,
    serial_to_parallel_rx_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W:0]   DATA_LIMIT = (CNT_W + 1)'(FRAME_BITS);

    rx_state_e             state_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic [FRAME_BITS-1:0] dout_r;
    logic                  rdy_r;
    logic                  ovf_r;
    logic                  err_r;

    logic [CNT_W-1:0]      cnt_s;
    logic                  tc_s;
    logic                  cnt_clr_s;
    logic                  cnt_en_s;
    logic                  shift_en_s;
    logic                  last_s;
    logic                  frame_err_s;
    logic                  par_err_s;
    logic                  deliver_s;
    logic [FRAME_BITS-1:0] word_s;

    rx_bit_counter #(
        .WIDTH (CNT_W),
        .LAST  (CNT_LAST)
    ) u_bit_counter (
        .ck    (ck),
        .reset (reset),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .cnt   (cnt_s),
        .tc    (tc_s)
    );

    // frame progress decode: last-bit detection, framing error, counter control
    always_comb begin
        last_s      = 1'b0;
        frame_err_s = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;
        shift_en_s  = bus.vi & ({1'b0, cnt_s} < DATA_LIMIT);
        case (state_r)
            IDLE: begin
                cnt_en_s = bus.vi;
            end
            RECV: begin
                if (bus.vi) begin
                    last_s    = tc_s;
                    cnt_clr_s = tc_s;
                    cnt_en_s  = ~tc_s;
                end else begin
                    frame_err_s = 1'b1;
                    cnt_clr_s   = 1'b1;
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // completed word and its acceptance; the final data bit is still on sin when parity is off
    always_comb begin
`ifdef PARITY_EN
        word_s    = shift_r;
        par_err_s = last_s & (even_parity(shift_r) != bus.sin);
`else
        word_s    = {bus.sin, shift_r[FRAME_BITS-1:1]};
        par_err_s = 1'b0;
`endif
        deliver_s = last_s & ~par_err_s;
    end

    // FSM, shift register and all registered outputs
    always_ff @(posedge ck) begin
        if (reset) begin
            state_r <= IDLE;
            shift_r <= '0;
            dout_r  <= '0;
            rdy_r   <= 1'b0;
            ovf_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            err_r <= frame_err_s | par_err_s;

            if (shift_en_s) begin
                shift_r <= {bus.sin, shift_r[FRAME_BITS-1:1]};
            end else begin
                shift_r <= shift_r;
            end

            case (state_r)
                IDLE: state_r <= bus.vi ? RECV : IDLE;
                RECV: state_r <= (!bus.vi || tc_s) ? IDLE : RECV;
                default: state_r <= IDLE;
            endcase

            // a same-cycle ack frees the holding slot, so the new word is never an overrun
            if (deliver_s) begin
                if (!rdy_r || bus.ack) begin
                    dout_r <= word_s;
                    rdy_r  <= 1'b1;
                end else begin
                    ovf_r  <= 1'b1;
                end
            end else if (rdy_r && bus.ack) begin
                rdy_r <= 1'b0;
            end else begin
                rdy_r <= rdy_r;
            end
        end
    end

    assign bus.dout = dout_r;
    assign bus.rdy  = rdy_r;
    assign bus.ovf  = ovf_r;
    assign bus.err  = err_r;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Bench for serial_to_parallel_rx: directed frames plus random traffic against a bit-queue reference model.
module tb_serial_to_parallel_rx;
    import serial_link_pkg::*;

    localparam int FB = 8;
`ifdef PARITY_EN
    localparam int FLEN = FB + 1;
`else
    localparam int FLEN = FB;
`endif

    logic ck = 1'b0;
    logic reset;

    serial_to_parallel_rx_if bus ();

    serial_to_parallel_rx dut (
        .ck    (ck),
        .reset (reset),
        .bus   (bus)
    );

    always #5 ck = ~ck;

    int checks = 0;
    int errors = 0;

    // reference model: bits of the frame in flight and the consumer-visible state
    bit       q[$];
    bit [7:0] m_dout = 8'h00;
    bit       m_rdy  = 1'b0;
    bit       m_ovf  = 1'b0;
    bit       m_err  = 1'b0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit vi, input bit sin, input bit ack);
        bit       done;
        bit [7:0] w;
        int       ones;
        if (r) begin
            q.delete();
            m_dout = 8'h00; m_rdy = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
            return;
        end
        done  = 1'b0;
        m_err = 1'b0;
        w     = 8'h00;
        ones  = 0;
        if (vi) begin
            q.push_back(sin);
            if (q.size() == FLEN) begin
                for (int i = 0; i < FB; i++) begin
                    w[i] = q[i];
                    ones += int'(q[i]);
                end
`ifdef PARITY_EN
                if (((ones + int'(q[FB])) % 2) == 0) done = 1'b1;
                else m_err = 1'b1;
`else
                done = 1'b1;
`endif
                q.delete();
            end
        end else if (q.size() != 0) begin
            m_err = 1'b1;
            q.delete();
        end
        if (done) begin
            if (!m_rdy || ack) begin
                m_dout = w;
                m_rdy  = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (ack && m_rdy) begin
            m_rdy = 1'b0;
        end
    endtask

    task automatic cyc(input bit r, input bit vi, input bit sin, input bit ack);
        reset  = r;
        bus.vi = vi; bus.sin = sin; bus.ack = ack;
        @(posedge ck);
        model_edge(r, vi, sin, ack);
        #1;
        check_val("dout", bus.dout, m_dout);
        check_val("rdy", 8'(bus.rdy), 8'(m_rdy));
        check_val("ovf", 8'(bus.ovf), 8'(m_ovf));
        check_val("err", 8'(bus.err), 8'(m_err));
    endtask

    // am: 0 = never ack, 1 = ack whenever a word is held, 2 = ack only on the last bit
    task automatic send_frame(input logic [7:0] w, input bit bad_par, input int am);
        bit a;
        bit b;
        for (int i = 0; i < FLEN; i++) begin
            b = (i < FB) ? w[i] : ((^w) ^ bad_par);
            a = (am == 1) ? m_rdy : ((am == 2) && (i == FLEN - 1));
            cyc(1'b0, 1'b1, b, a);
        end
    endtask

    initial begin
        logic [7:0] w;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rst_dout", bus.dout, 8'h00);
        check_val("rst_flags", 8'({bus.rdy, bus.ovf, bus.err}), 8'h00);

        send_frame(8'hA5, 1'b0, 0);
        check_val("a5_rdy", 8'(bus.rdy), 8'h01);
        check_val("a5_dout", bus.dout, 8'hA5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("a5_ack_rdy", 8'(bus.rdy), 8'h00);
        check_val("a5_ack_dout", bus.dout, 8'hA5);

        send_frame(8'h3C, 1'b0, 1);
        check_val("b2b_first", bus.dout, 8'h3C);
        send_frame(8'hC3, 1'b0, 1);
        check_val("b2b_second", bus.dout, 8'hC3);
        check_val("b2b_ovf", 8'(bus.ovf), 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        send_frame(8'h11, 1'b0, 0);
        send_frame(8'h22, 1'b0, 0);
        check_val("ovr_ovf", 8'(bus.ovf), 8'h01);
        check_val("ovr_dout", bus.dout, 8'h11);
        check_val("ovr_rdy", 8'(bus.rdy), 8'h01);
        send_frame(8'h22, 1'b0, 2);
        check_val("ackc_dout", bus.dout, 8'h22);
        check_val("ackc_ovf", 8'(bus.ovf), 8'h01);

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("frm_err", 8'(bus.err), 8'h01);
        check_val("frm_rdy", 8'(bus.rdy), 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("frm_err_end", 8'(bus.err), 8'h00);
        send_frame(8'h7E, 1'b0, 0);
        check_val("frm_next", bus.dout, 8'h7E);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 0);
        check_val("rstmid_dout", bus.dout, 8'h81);
        check_val("rstmid_flags", 8'({bus.ovf, bus.err}), 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef PARITY_EN
        send_frame(8'hA5, 1'b0, 0);
        check_val("par_good_rdy", 8'(bus.rdy), 8'h01);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b1, 0);
        check_val("par_bad_err", 8'(bus.err), 8'h01);
        check_val("par_bad_rdy", 8'(bus.rdy), 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            w = 8'($urandom);
            send_frame(w, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                cyc(1'b0, 1'b0, 1'b0, ($urandom_range(0, 1) == 1));
        end
        for (int n = 0; n < 2000; n++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_rx.md
# serial_to_parallel_rx

Receiving end of the serial data link: samples the bit-serial stream produced by the parallel-to-serial transmitter (data plus a frame-valid strobe) and reassembles each 8-bit frame into a parallel word. Completed words are held for a downstream consumer behind a ready/acknowledge handshake, with sticky overrun and per-frame error reporting. Sits directly on the link wires, one per serial channel.

## Interface
- FRAME_BITS, 8: data bits per frame; must be even (upper/lower nibble split); 8 is the only verified value.
- ck  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- vi  in  1  frame valid; high for every data bit of a frame (driven by the transmitter's VO).
- sin  in  1  serial data, sampled on rising ck when vi=1.
- ack  in  1  consumer acknowledge; consumes the held word when rdy=1.
- dout  out  FRAME_BITS  last accepted word; reset 0.
- rdy  out  1  dout holds an unconsumed word; reset 0.
- ovf  out  1  sticky overrun flag; reset 0.
- err  out  1  one-cycle error pulse; reset 0.

## Operation
- Bit order is LSB first: the n-th sampled bit of a frame (n=0..7) lands in dout[n]. dout[7:4] is therefore the transmitter's LD1 nibble and dout[3:0] its LD2 nibble.
- States:
  - IDLE: bit counter = 0. vi=1 samples bit 0 and moves to RECV.
  - RECV: each vi=1 cycle shifts sin in and increments the counter. When the last bit is sampled (or the parity bit, under PARITY_EN), the frame completes and the FSM returns to IDLE.
  - A vi=0 cycle in RECV is a framing error: err pulses, the partial frame is discarded, the counter clears, and the FSM returns to IDLE.
- Frame completion with rdy=0: dout loads the assembled word and rdy is set.
- Frame completion with rdy=1 and ack=0: overrun.
  - dout keeps the old word.
  - The new word is dropped.
  - ovf sets and stays set until reset.
  - rdy stays 1.
- Frame completion with rdy=1 and ack=1 in the same cycle: the new word loads, rdy stays 1, no overrun.
- ack with rdy=1 and no completion: rdy clears on the next edge. dout is unchanged (it retains the last word).
- ack with rdy=0 has no effect.
- vi held high across frames gives back-to-back frames: the cycle after completion samples bit 0 of the next frame with no gap.
- Reset in any state clears the FSM, counter, shift register, dout, rdy, ovf and err. A partial frame is lost.

## Timing
- The edge that samples the final bit also sets rdy and loads dout. Both are valid in the cycle immediately after the last vi=1 cycle, so latency from the last bit to rdy is 1 cycle.
- err goes high for exactly the one cycle following the offending edge.
- All outputs are registered; no combinational path from inputs to outputs.
- Minimum frame period is FRAME_BITS cycles (FRAME_BITS+1 with PARITY_EN).

## Configuration
- PARITY_EN defined:
  - The frame is FRAME_BITS+1 bits; the extra bit is even parity over the data, sent last.
  - On mismatch, err pulses, the word is dropped, and rdy and ovf are unaffected.
  - The counter spans 0..FRAME_BITS.
- PARITY_EN undefined:
  - The frame is FRAME_BITS bits.
  - err reports framing errors only.
  - No parity logic is generated.

## Structure
- Package serial_link_pkg holds:
  - FRAME_BITS default;
  - the FSM state enum (IDLE, RECV);
  - the counter width constant, derived from FRAME_BITS plus the parity option.
- The transmitter side imports the same package.
- One sub-module, rx_bit_counter: clear/enable counter with a terminal-count output. Used here and reusable by the transmitter controller.

## Test plan
- After reset: all outputs 0. Send 0xA5 (bits 1,0,1,0,0,1,0,1 with vi=1 for 8 cycles) → rdy=1 and dout=8'hA5 one cycle after the last bit; pulse ack → rdy=0 next cycle, dout stays 8'hA5.
- Back-to-back frames 0x3C, 0xC3 with vi continuously high and ack pulsed on each rdy → both words delivered in order, ovf=0.
- Frame 0x11 left unacknowledged, then frame 0x22 → ovf=1 (sticky), dout=8'h11, rdy=1. Repeat with ack asserted on 0x22's completion cycle → dout=8'h22, ovf unchanged.
- vi dropped after 5 bits → err high for 1 cycle, rdy unchanged. Following full frame 0x7E → dout=8'h7E.
- reset asserted at bit 3 of a frame, then frame 0x81 → only 0x81 is received; ovf=0, err=0.
- PARITY_EN: 0xA5 with parity bit 0 → rdy=1. 0xA5 with parity bit 1 → err pulse, rdy stays 0.
